mdu_divider: RTL and testbench

//  Iterative radix-2 restoring divider. It is the responder side of the ALU's div_op/done handshake inside the MDU.

---
 rtl/mdu_pkg.sv | 15 +
 rtl/div_iter_step.sv | 22 ++
 rtl/mdu_divider.sv | 116 +++++++++++
 tb/tb_mdu_divider.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: request opcodes and divider FSM states.
// Used by both the divider and the multiplier.
package mdu_pkg;

    localparam logic [1:0] MDU_OP_NONE     = 2'b00;
    localparam logic [1:0] MDU_OP_UNSIGNED = 2'b01;
    localparam logic [1:0] MDU_OP_SIGNED   = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIXUP
    } div_state_t;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step.
// Shift in a dividend bit, trial-subtract, keep or restore.
module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Extra MSB keeps the borrow of the trial subtraction.
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, divisor_i};
    assign q_o     = ~diff[WIDTH];
    assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring divider for the MDU.
// Returns {remainder, quotient}; done is low while a division runs.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         div_op,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] result,
    output logic               done
);

    localparam int CW = $clog2(WIDTH);

    div_state_t         state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH-1:0]   raw_q;
    logic               qneg_q;
    logic               rneg_q;
    logic               zero_q;
    logic [2*WIDTH-1:0] result_q;
    logic               done_q;

    logic               accept;
    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] result_d;

    assign is_signed = (div_op == MDU_OP_SIGNED);
    assign accept    = is_signed || (div_op == MDU_OP_UNSIGNED);
    assign a_neg     = is_signed && dividend[WIDTH-1];
    assign b_neg     = is_signed && divisor[WIDTH-1];
    assign abs_a     = a_neg ? -dividend : dividend;
    assign abs_b     = b_neg ? -divisor : divisor;

    // The dividend is shifted out of quo_q MSB-first as quotient bits enter.
    div_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    assign quo_fix  = qneg_q ? -quo_q : quo_q;
    assign rem_fix  = rneg_q ? -rem_q : rem_q;
    assign result_d = zero_q ? {raw_q, {WIDTH{1'b1}}}
                             : {rem_fix, quo_fix};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            raw_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b1;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (accept) begin
                        rem_q   <= '0;
                        quo_q   <= abs_a;
                        dvs_q   <= abs_b;
                        raw_q   <= dividend;
                        qneg_q  <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        zero_q  <= (divisor == '0);
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        state_q <= DIV_CALC;
                    end
                end
                DIV_CALC: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[WIDTH-2:0], step_q};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= DIV_FIXUP;
                    end
                end
                DIV_FIXUP: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    state_q  <= DIV_IDLE;
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Self-checking bench for mdu_divider.
// Directed cases plus randomized pairs against a / and % reference.
module tb_mdu_divider;

    logic        clk;
    logic        rst;
    logic [1:0]  div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [63:0] result;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;
    int rises    = 0;

    mdu_divider #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .div_op   (div_op),
        .dividend (dividend),
        .divisor  (divisor),
        .result   (result),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: count done rising edges and check result holds while idle.
    logic        prev_done;
    logic [63:0] prev_res;
    always @(posedge clk) begin
        #1;
        if (prev_done === 1'b1 && done === 1'b1 && rst === 1'b0) begin
            n_checks++;
            if (result !== prev_res)
                $display("FAIL stable: result=%h required=%h", result, prev_res);
            else
                n_pass++;
        end
        if (prev_done === 1'b0 && done === 1'b1) rises++;
        prev_done = done;
        prev_res  = result;
    end

    function automatic logic [63:0] ref_div(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return {32'd0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic run_div(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, output logic [63:0] res,
                           output int lat);
        @(negedge clk);
        div_op   = op;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        div_op   = 2'b00;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
    endtask

    task automatic check_div(input string name, input logic [1:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        logic [63:0] res, exp;
        int lat;
        exp = ref_div(op, a, b);
        run_div(op, a, b, res, lat);
        n_checks++;
        if (res !== exp)
            $display("FAIL %s: result=%h required=%h", name, res, exp);
        else
            n_pass++;
        n_checks++;
        if (lat != 33)
            $display("FAIL %s_latency: cycles=%0d required=33", name, lat);
        else
            n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        div_op = 2'b00;
        dividend = 32'd0;
        divisor = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || result !== 64'd0)
            $display("FAIL reset: done=%b result=%h required 1/0", done, result);
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_divu_basic;
        int r0;
        r0 = rises;
        check_div("divu_100_7", 2'b01, 32'd100, 32'd7);
        n_checks++;
        if (rises - r0 != 1)
            $display("FAIL done_rise: rises=%0d required=1", rises - r0);
        else
            n_pass++;
    endtask

    task automatic test_signed;
        check_div("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        check_div("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_overflow;
        check_div("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check_div("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);
    endtask

    task automatic test_div_zero;
        check_div("divu_5_0", 2'b01, 32'd5, 32'd0);
        check_div("div_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0);
    endtask

    task automatic test_no_request;
        int r0;
        r0 = rises;
        @(negedge clk);
        div_op = 2'b11;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || rises != r0)
            $display("FAIL op11_idle: done=%b rises=%0d required 1/%0d",
                     done, rises, r0);
        else
            n_pass++;
        @(negedge clk);
        div_op = 2'b00;
    endtask

    task automatic test_busy_ignore;
        int lat;
        @(negedge clk);
        div_op = 2'b01;
        dividend = 32'd100;
        divisor = 32'd7;
        @(posedge clk);
        #1;
        div_op = 2'b00;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            if (lat == 9) begin
                div_op = 2'b10;
                dividend = 32'd9;
                divisor = 32'd3;
            end
            if (lat == 20) div_op = 2'b00;
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (result !== {32'd2, 32'd14} || lat != 33)
            $display("FAIL busy_ignore: result=%h cycles=%0d required=%h/33",
                     result, lat, {32'd2, 32'd14});
        else
            n_pass++;
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        div_op = 2'b01;
        dividend = 32'd100;
        divisor = 32'd7;
        @(posedge clk);
        #1;
        div_op = 2'b00;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || result !== 64'd0)
            $display("FAIL reset_abort: done=%b result=%h required 1/0",
                     done, result);
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b0;
        check_div("after_abort", 2'b01, 32'd9, 32'd3);
    endtask

    task automatic test_back_to_back;
        check_div("b2b_a", 2'b10, 32'hFFFF_FF9C, 32'd9);
        check_div("b2b_b", 2'b01, 32'hDEAD_BEEF, 32'h0000_1234);
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            a  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF;
                3: b = -($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            check_div("random", op, a, b);
        end
    endtask

    initial begin
        test_reset;
        test_divu_basic;
        test_signed;
        test_overflow;
        test_div_zero;
        test_no_request;
        test_busy_ignore;
        test_reset_abort;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
